// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    // Default operand width; the quotient takes one clock per bit.
    localparam int WIDTH_DEF = 32;

    // Iteration counter width for the default operand width.
    localparam int CNT_W = $clog2(WIDTH_DEF);

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_FIN  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
//
// Ports:
//   rem_in    partial remainder entering the step (always < divisor)
//   dvd_msb   next dividend bit shifted into the remainder
//   divisor   magnitude of the divisor
//   rem_out   partial remainder leaving the step
//   q_bit     quotient bit produced by the step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so the shifted value stays below 2*divisor and fits
    // in WIDTH+1 bits; the top bit of the difference is the borrow.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative signed/unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     synchronous reset, active-high
//   start   request, sampled only in idle
//   ina     dividend, sampled with start
//   inb     divisor, sampled with start
//   sign    1 = two's-complement signed, 0 = unsigned, sampled with start
//   busy    high from the cycle after acceptance through the done cycle
//   done    one-cycle pulse, out/divz valid from this cycle
//   divz    divisor was zero for the completed operation
//   out     {remainder, quotient}, held until the next completion
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic               sign,
    output logic               busy,
    output logic               done,
    output logic               divz,
    output logic [2*WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state_q;
    div_state_t state_nx;

    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   abs_b_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic               sign_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               zero_b_q;
    logic [2*WIDTH-1:0] out_q;
    logic               divz_q;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               neg_a_in;
    logic               neg_b_in;

    // The dividend register doubles as the quotient register: its msb feeds
    // the step while the new quotient bit enters at the lsb.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (abs_b_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: if (start) state_nx = ST_CALC;
            ST_CALC: if (cnt_q == CW'(WIDTH - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_FIN;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_CALC: busy = 1'b1;
            ST_FIX:  busy = 1'b1;
            ST_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign neg_a_in = sign & ina[WIDTH-1];
    assign neg_b_in = sign & inb[WIDTH-1];

    // Sign correction of the magnitude result. Truncating division: the
    // remainder follows the dividend's sign. A zero divisor bypasses the
    // fix and returns the raw dividend with an all-ones quotient.
    always_comb begin
        q_fix = dvd_q;
        r_fix = rem_q;
        if (sign_q && (neg_a_q ^ neg_b_q)) begin
            q_fix = -dvd_q;
        end
        if (sign_q && neg_a_q) begin
            r_fix = -rem_q;
        end
        if (zero_b_q) begin
            q_fix = '1;
            r_fix = raw_a_q;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            abs_b_q  <= '0;
            raw_a_q  <= '0;
            sign_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            zero_b_q <= 1'b0;
            out_q    <= '0;
            divz_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        dvd_q    <= neg_a_in ? -ina : ina;
                        abs_b_q  <= neg_b_in ? -inb : inb;
                        raw_a_q  <= ina;
                        sign_q   <= sign;
                        neg_a_q  <= neg_a_in;
                        neg_b_q  <= neg_b_in;
                        zero_b_q <= (inb == '0);
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_FIX: begin
                    out_q  <= {r_fix, q_fix};
                    divz_q <= zero_b_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign out  = out_q;
    assign divz = divz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq
module tb_div32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ina;
    logic [31:0] inb;
    logic        sign;
    logic        busy;
    logic        done;
    logic        divz;
    logic [63:0] out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    div32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ina   (ina),
        .inb   (inb),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .divz  (divz),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        ina   = '0;
        inb   = '0;
        sign  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one operation and waits for its completion. lat counts clock
    // edges from the accepting edge through the edge that raises done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [63:0] res, output logic dz,
                          output logic bsy_ok, output int acc);
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        ina   = a;
        inb   = b;
        sign  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        acc    = cyc;
        lat    = 1;
        bsy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) bsy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) bsy_ok = 1'b0;
        res = out;
        dz  = divz;
        @(posedge clk);
        #1;
        if (busy || done) bsy_ok = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (divz !== 1'b0) begin fails++; $display("FAIL reset_divz got %b want 0", divz); end
        tests++; if (out !== 64'h0) begin fails++; $display("FAIL reset_out got %h want 0", out); end
    endtask

    task automatic test_unsigned();
        int lat, acc;
        logic [63:0] res;
        logic dz, bok;
        run_op(32'd100, 32'd7, 1'b0, lat, res, dz, bok, acc);
        tests++; if (lat !== 34) begin fails++; $display("FAIL unsigned_latency got %0d want 34", lat); end
        tests++; if (res !== {32'd2, 32'd14}) begin fails++; $display("FAIL unsigned_out got %h want %h", res, {32'd2, 32'd14}); end
        tests++; if (dz !== 1'b0) begin fails++; $display("FAIL unsigned_divz got %b want 0", dz); end
        tests++; if (bok !== 1'b1) begin fails++; $display("FAIL unsigned_busy_window got %b want 1", bok); end
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, lat, res, dz, bok, acc);
        tests++; if (res !== {32'd0, 32'hFFFFFFFF}) begin fails++; $display("FAIL unsigned_max_by_one got %h want %h", res, {32'd0, 32'hFFFFFFFF}); end
    endtask

    task automatic test_signed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [63:0] ve [4];
        int lat, acc;
        logic [63:0] res;
        logic dz, bok;
        va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        ve[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
        va[1] = 32'h7;        vb[1] = 32'hFFFFFFFE; ve[1] = {32'h1,        32'hFFFFFFFD};
        va[2] = 32'hFFFFFFF9; vb[2] = 32'hFFFFFFFE; ve[2] = {32'hFFFFFFFF, 32'h3};
        va[3] = 32'd1000;     vb[3] = 32'hFFFFFFF6; ve[3] = {32'h0,        32'hFFFFFF9C};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b1, lat, res, dz, bok, acc);
            tests++;
            if (res !== ve[i] || dz !== 1'b0 || lat !== 34) begin
                fails++;
                $display("FAIL signed_vec%0d got out=%h divz=%b lat=%0d want out=%h divz=0 lat=34",
                         i, res, dz, lat, ve[i]);
            end
        end
    endtask

    task automatic test_divzero();
        int lat, acc;
        logic [63:0] res;
        logic dz, bok;
        run_op(32'd5, 32'd0, 1'b0, lat, res, dz, bok, acc);
        tests++; if (res !== {32'h5, 32'hFFFFFFFF}) begin fails++; $display("FAIL divzero_out got %h want %h", res, {32'h5, 32'hFFFFFFFF}); end
        tests++; if (dz !== 1'b1) begin fails++; $display("FAIL divzero_divz got %b want 1", dz); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL divzero_latency got %0d want 34", lat); end
        run_op(32'hFFFFFFFB, 32'd0, 1'b1, lat, res, dz, bok, acc);
        tests++; if (res !== {32'hFFFFFFFB, 32'hFFFFFFFF} || dz !== 1'b1) begin
            fails++; $display("FAIL divzero_signed got out=%h divz=%b want out=%h divz=1", res, dz, {32'hFFFFFFFB, 32'hFFFFFFFF});
        end
    endtask

    task automatic test_overflow();
        int lat, acc;
        logic [63:0] res;
        logic dz, bok;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res, dz, bok, acc);
        tests++; if (res !== {32'h0, 32'h80000000} || dz !== 1'b0) begin
            fails++; $display("FAIL overflow_signed got out=%h divz=%b want out=%h divz=0", res, dz, {32'h0, 32'h80000000});
        end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, res, dz, bok, acc);
        tests++; if (res !== {32'h80000000, 32'h0} || dz !== 1'b0) begin
            fails++; $display("FAIL overflow_unsigned got out=%h divz=%b want out=%h divz=0", res, dz, {32'h80000000, 32'h0});
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        logic [63:0] res;
        res = '0;
        @(negedge clk);
        ina = 32'd100; inb = 32'd7; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ina = 32'd9; inb = 32'd3; sign = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 10);
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                res = out;
            end
        end
        start = 1'b0;
        tests++; if (n_done !== 1) begin fails++; $display("FAIL busy_start_done_count got %0d want 1", n_done); end
        tests++; if (res !== {32'd2, 32'd14}) begin fails++; $display("FAIL busy_start_result got %h want %h", res, {32'd2, 32'd14}); end
    endtask

    task automatic test_start_in_fin();
        int guard, n_done;
        @(negedge clk);
        ina = 32'd20; inb = 32'd3; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        tests++; if (out !== {32'd2, 32'd6}) begin fails++; $display("FAIL fin_first_result got %h want %h", out, {32'd2, 32'd6}); end
        ina = 32'd1; inb = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fin_start_ignored busy got %b want 0", busy); end
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        tests++; if (n_done !== 0 || out !== {32'd2, 32'd6}) begin
            fails++; $display("FAIL fin_start_no_op got dones=%0d out=%h want dones=0 out=%h", n_done, out, {32'd2, 32'd6});
        end
    endtask

    task automatic test_reset_abort();
        int n_done, lat, acc;
        logic [63:0] res;
        logic dz, bok;
        @(negedge clk);
        ina = 32'd1000; inb = 32'd10; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_status got busy=%b done=%b want 0 0", busy, done); end
        tests++; if (out !== 64'h0 || divz !== 1'b0) begin fails++; $display("FAIL abort_out got out=%h divz=%b want 0 0", out, divz); end
        n_done = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        tests++; if (n_done !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        run_op(32'd1000, 32'd10, 1'b0, lat, res, dz, bok, acc);
        tests++; if (res !== {32'd0, 32'd100} || lat !== 34) begin
            fails++; $display("FAIL abort_recover got out=%h lat=%0d want out=%h lat=34", res, lat, {32'd0, 32'd100});
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, acc1, acc2;
        logic [63:0] r1, r2;
        logic dz1, dz2, b1, b2;
        run_op(32'd77, 32'd5, 1'b0, lat1, r1, dz1, b1, acc1);
        run_op(32'hFFFFFF9C, 32'd7, 1'b1, lat2, r2, dz2, b2, acc2);
        tests++; if (acc2 - acc1 !== 35) begin fails++; $display("FAIL b2b_spacing got %0d want 35", acc2 - acc1); end
        tests++; if (r1 !== {32'd2, 32'd15} || r2 !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin
            fails++; $display("FAIL b2b_results got %h %h want %h %h", r1, r2, {32'd2, 32'd15}, {32'hFFFFFFFE, 32'hFFFFFFF2});
        end
        tests++; if (b1 !== 1'b1 || b2 !== 1'b1 || lat2 !== 34) begin
            fails++; $display("FAIL b2b_timing got busy_ok=%b%b lat=%0d want 11 34", b1, b2, lat2);
        end
    endtask

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        logic dz;
        dz = 1'b0;
        if (b == 32'h0) begin
            q = 32'hFFFFFFFF; r = a; dz = 1'b1;
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000; r = 32'h0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {dz, r, q};
    endfunction

    task automatic test_random();
        int lat, acc;
        logic [63:0] res;
        logic dz, bok, s;
        logic [31:0] a, b;
        logic [64:0] exp_v;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            s = $urandom_range(0, 1);
            exp_v = model(a, b, s);
            run_op(a, b, s, lat, res, dz, bok, acc);
            tests++;
            if (res !== exp_v[63:0] || dz !== exp_v[64] || lat !== 34 || bok !== 1'b1) begin
                fails++;
                $display("FAIL random%0d a=%h b=%h s=%b got out=%h divz=%b lat=%0d busy_ok=%b want out=%h divz=%b lat=34",
                         i, a, b, s, res, dz, lat, bok, exp_v[63:0], exp_v[64]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ina = '0; inb = '0; sign = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_start_while_busy();
        test_start_in_fin();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
